// File: rtl/core_pkg.sv
// Shared encodings for the write-back path: result-source select, load size
// and the zero-register index.
package core_pkg;

    localparam logic [1:0] WB_SEL_ALU  = 2'b00;
    localparam logic [1:0] WB_SEL_MEM  = 2'b01;
    localparam logic [1:0] WB_SEL_LINK = 2'b10;
    localparam logic [1:0] WB_SEL_ZERO = 2'b11;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] SIZE_D = 2'b11;

    // XZR for the architectural 5-bit register index.
    localparam logic [4:0] XZR_IDX = 5'd31;

endpackage

// File: rtl/load_ext.sv
// Combinational load formatter: keeps the low 8/16/32/64 bits of right-aligned
// load data and zero- or sign-extends them to DATA_W.
module load_ext
    import core_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic [DATA_W-1:0] raw,
    input  logic [1:0]        size,
    input  logic              is_signed,
    output logic [DATA_W-1:0] ext
);

    always_comb begin
        ext = raw;
        case (size)
            SIZE_B:  ext = {{(DATA_W-8){is_signed & raw[7]}},   raw[7:0]};
            SIZE_H:  ext = {{(DATA_W-16){is_signed & raw[15]}}, raw[15:0]};
            SIZE_W:  ext = {{(DATA_W-32){is_signed & raw[31]}}, raw[31:0]};
            // Doubleword ignores is_signed; bits above 64 are left as loaded.
            default: ext = raw;
        endcase
    end

endmodule

// File: rtl/wb_stage_pipe.sv
// MEM/WB pipeline stage: selects and formats the result, registers it under
// stall/flush control, drives the register-file write port and counts retires.
module wb_stage_pipe
    import core_pkg::*;
#(
    parameter int DATA_W      = 64,
    parameter int REG_AW      = 5,
    parameter int CNT_W       = 32,
    parameter int ZR_SUPPRESS = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              in_regwrite,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [1:0]        in_wb_sel,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [DATA_W-1:0] in_mem,
    input  logic [DATA_W-1:0] in_link,
    input  logic [1:0]        in_size,
    input  logic              in_signed,
    input  logic              stall,
    input  logic              flush,
    output logic              wb_we,
    output logic [REG_AW-1:0] wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              fwd_valid,
    output logic [CNT_W-1:0]  retired
);

    // Handshake: the upstream stage offers an instruction with in_valid; the
    // stage accepts it on any edge where stall=0 or flush=1 (flush accepts a
    // bubble). The occupant leaves, and is retired, on that same edge.

    logic [DATA_W-1:0] load_fmt;
    logic [DATA_W-1:0] sel_data;
    logic              advance;
    logic              rd_is_zr;

    logic              valid_q, valid_d;
    logic              regwrite_q, regwrite_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  retired_q, retired_d;

    load_ext #(.DATA_W(DATA_W)) u_load_ext (
        .raw       (in_mem),
        .size      (in_size),
        .is_signed (in_signed),
        .ext       (load_fmt)
    );

    always_comb begin
        sel_data = '0;
        case (in_wb_sel)
            WB_SEL_ALU:  sel_data = in_alu;
            WB_SEL_MEM:  sel_data = load_fmt;
            WB_SEL_LINK: sel_data = in_link;
            default:     sel_data = '0;
        endcase
    end

    assign advance = ~stall | flush;

    always_comb begin
        valid_d    = valid_q;
        regwrite_d = regwrite_q;
        rd_d       = rd_q;
        data_d     = data_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (!stall) begin
            valid_d    = in_valid;
            regwrite_d = in_regwrite;
            rd_d       = in_rd;
            data_d     = sel_data;
        end
        retired_d = retired_q + CNT_W'(valid_q & advance);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            rd_q       <= '0;
            data_q     <= '0;
            retired_q  <= '0;
        end else begin
            valid_q    <= valid_d;
            regwrite_q <= regwrite_d;
            rd_q       <= rd_d;
            data_q     <= data_d;
            retired_q  <= retired_d;
        end
    end

    // valid_q is never X after reset, so it masks any X in the data fields.
    assign rd_is_zr  = (ZR_SUPPRESS != 0) && (rd_q == {REG_AW{1'b1}});
    assign wb_we     = valid_q & regwrite_q & ~rd_is_zr;
    assign fwd_valid = wb_we;
    assign wb_rd     = rd_q;
    assign wb_data   = data_q;
    assign retired   = retired_q;

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Directed bench for wb_stage_pipe: three instances share the stimulus to
// cover the default, ZR_SUPPRESS=0 and CNT_W=4 configurations.
module tb_wb_stage_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_regwrite;
    logic [4:0]  in_rd;
    logic [1:0]  in_wb_sel;
    logic [63:0] in_alu;
    logic [63:0] in_mem;
    logic [63:0] in_link;
    logic [1:0]  in_size;
    logic        in_signed;
    logic        stall;
    logic        flush;

    logic        wb_we, fwd_valid;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic [31:0] retired;

    logic        nz_wb_we, nz_fwd_valid;
    logic [4:0]  nz_wb_rd;
    logic [63:0] nz_wb_data;
    logic [31:0] nz_retired;

    logic        c4_wb_we, c4_fwd_valid;
    logic [4:0]  c4_wb_rd;
    logic [63:0] c4_wb_data;
    logic [3:0]  c4_retired;

    int n_cmp  = 0;
    int n_fail = 0;

    wb_stage_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_regwrite(in_regwrite),
        .in_rd(in_rd), .in_wb_sel(in_wb_sel), .in_alu(in_alu), .in_mem(in_mem),
        .in_link(in_link), .in_size(in_size), .in_signed(in_signed),
        .stall(stall), .flush(flush), .wb_we(wb_we), .wb_rd(wb_rd),
        .wb_data(wb_data), .fwd_valid(fwd_valid), .retired(retired)
    );

    wb_stage_pipe #(.ZR_SUPPRESS(0)) dut_nz (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_regwrite(in_regwrite),
        .in_rd(in_rd), .in_wb_sel(in_wb_sel), .in_alu(in_alu), .in_mem(in_mem),
        .in_link(in_link), .in_size(in_size), .in_signed(in_signed),
        .stall(stall), .flush(flush), .wb_we(nz_wb_we), .wb_rd(nz_wb_rd),
        .wb_data(nz_wb_data), .fwd_valid(nz_fwd_valid), .retired(nz_retired)
    );

    wb_stage_pipe #(.CNT_W(4)) dut_c4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_regwrite(in_regwrite),
        .in_rd(in_rd), .in_wb_sel(in_wb_sel), .in_alu(in_alu), .in_mem(in_mem),
        .in_link(in_link), .in_size(in_size), .in_signed(in_signed),
        .stall(stall), .flush(flush), .wb_we(c4_wb_we), .wb_rd(c4_wb_rd),
        .wb_data(c4_wb_data), .fwd_valid(c4_fwd_valid), .retired(c4_retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rw, input logic [4:0] rd,
                         input logic [1:0] sel, input logic [63:0] alu,
                         input logic [63:0] mem, input logic [1:0] sz, input logic sg);
        in_valid    = v;
        in_regwrite = rw;
        in_rd       = rd;
        in_wb_sel   = sel;
        in_alu      = alu;
        in_mem      = mem;
        in_size     = sz;
        in_signed   = sg;
    endtask

    initial begin
        rst_n = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        in_link = 64'h0;
        drive(1'b0, 1'b0, 5'd0, 2'b00, 64'h0, 64'h0, 2'b00, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;

        chk("rst_we",      64'(wb_we),     64'h0);
        chk("rst_fwd",     64'(fwd_valid), 64'h0);
        chk("rst_rd",      64'(wb_rd),     64'h0);
        chk("rst_data",    wb_data,        64'h0);
        chk("rst_retired", 64'(retired),   64'h0);

        // Signed byte load.
        drive(1'b1, 1'b1, 5'd3, 2'b01, 64'h0, 64'h1280, 2'b00, 1'b1);
        tick();
        chk("ldsb_we",      64'(wb_we),     64'h1);
        chk("ldsb_fwd",     64'(fwd_valid), 64'h1);
        chk("ldsb_rd",      64'(wb_rd),     64'd3);
        chk("ldsb_data",    wb_data,        64'hFFFF_FFFF_FFFF_FF80);
        chk("ldsb_retired", 64'(retired),   64'd0);

        // Unsigned byte load.
        drive(1'b1, 1'b1, 5'd4, 2'b01, 64'h0, 64'h1280, 2'b00, 1'b0);
        tick();
        chk("ldub_data",    wb_data,      64'h80);
        chk("ldub_retired", 64'(retired), 64'd1);

        // Signed word load.
        drive(1'b1, 1'b1, 5'd6, 2'b01, 64'h0, 64'h8000_0000, 2'b10, 1'b1);
        tick();
        chk("ldsw_data", wb_data, 64'hFFFF_FFFF_8000_0000);

        // Signed half load.
        drive(1'b1, 1'b1, 5'd6, 2'b01, 64'h0, 64'hABCD_8001, 2'b01, 1'b1);
        tick();
        chk("ldsh_data", wb_data, 64'hFFFF_FFFF_FFFF_8001);

        // Doubleword ignores signed.
        drive(1'b1, 1'b1, 5'd6, 2'b01, 64'h0, 64'h8000_0000_0000_0001, 2'b11, 1'b1);
        tick();
        chk("ldd_data",    wb_data,      64'h8000_0000_0000_0001);
        chk("ldd_retired", 64'(retired), 64'd4);

        // Link source.
        in_link = 64'h40_0104;
        drive(1'b1, 1'b1, 5'd30, 2'b10, 64'h1111, 64'h2222, 2'b00, 1'b0);
        tick();
        chk("link_data", wb_data,     64'h40_0104);
        chk("link_rd",   64'(wb_rd),  64'd30);

        // Zero source.
        drive(1'b1, 1'b1, 5'd7, 2'b11, 64'h1234, 64'h5678, 2'b11, 1'b0);
        tick();
        chk("zero_data", wb_data, 64'h0);

        // ALU source.
        drive(1'b1, 1'b1, 5'd8, 2'b00, 64'hDEAD_BEEF_0000_0001, 64'h0, 2'b00, 1'b0);
        tick();
        chk("alu_data",    wb_data,      64'hDEAD_BEEF_0000_0001);
        chk("alu_retired", 64'(retired), 64'd7);

        // Load A, then stall three cycles while B is offered.
        drive(1'b1, 1'b1, 5'd5, 2'b00, 64'hAAAA, 64'h0, 2'b00, 1'b0);
        tick();
        chk("a_rd",      64'(wb_rd),   64'd5);
        chk("a_retired", 64'(retired), 64'd8);
        drive(1'b1, 1'b1, 5'd9, 2'b00, 64'hBBBB, 64'h0, 2'b00, 1'b0);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_rd",      64'(wb_rd),   64'd5);
            chk("stall_data",    wb_data,      64'hAAAA);
            chk("stall_we",      64'(wb_we),   64'h1);
            chk("stall_retired", 64'(retired), 64'd8);
        end
        stall = 1'b0;
        tick();
        chk("rel_rd",      64'(wb_rd),   64'd9);
        chk("rel_data",    wb_data,      64'hBBBB);
        chk("rel_retired", 64'(retired), 64'd9);

        // Flush beats stall; B still retires as it leaves.
        drive(1'b1, 1'b1, 5'd10, 2'b00, 64'hCCCC, 64'h0, 2'b00, 1'b0);
        stall = 1'b1;
        flush = 1'b1;
        tick();
        chk("flush_we",      64'(wb_we),     64'h0);
        chk("flush_fwd",     64'(fwd_valid), 64'h0);
        chk("flush_retired", 64'(retired),   64'd10);
        stall = 1'b0;
        flush = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 2'b00, 64'h0, 64'h0, 2'b00, 1'b0);
        tick();
        chk("bubble_retired", 64'(retired), 64'd10);

        // Write to XZR.
        drive(1'b1, 1'b1, 5'd31, 2'b00, 64'h55, 64'h0, 2'b00, 1'b0);
        tick();
        chk("xzr_we",    64'(wb_we),     64'h0);
        chk("xzr_fwd",   64'(fwd_valid), 64'h0);
        chk("xzr_nz_we", 64'(nz_wb_we),  64'h1);

        // Invalid slot with X data fields.
        in_valid    = 1'b0;
        in_regwrite = 1'bx;
        in_rd       = 'x;
        in_wb_sel   = 'x;
        in_alu      = 'x;
        in_mem      = 'x;
        in_size     = 'x;
        in_signed   = 1'bx;
        tick();
        chk("xinv_we",      64'(wb_we),     64'h0);
        chk("xinv_fwd",     64'(fwd_valid), 64'h0);
        chk("xzr_retired",  64'(retired),   64'd11);
        tick();
        chk("xinv_we2",     64'(wb_we),     64'h0);
        chk("idle_retired", 64'(retired),   64'd11);

        // Non-writing instruction.
        drive(1'b1, 1'b0, 5'd12, 2'b00, 64'h99, 64'h0, 2'b00, 1'b0);
        tick();
        chk("norw_we", 64'(wb_we), 64'h0);

        // Async reset mid-cycle with a live write in the stage.
        drive(1'b1, 1'b1, 5'd13, 2'b00, 64'h77, 64'h0, 2'b00, 1'b0);
        tick();
        chk("pre_rst_we", 64'(wb_we), 64'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_we",         64'(wb_we),      64'h0);
        chk("arst_data",       wb_data,         64'h0);
        chk("arst_retired",    64'(retired),    64'd0);
        chk("arst_c4_retired", 64'(c4_retired), 64'd0);
        #1;
        rst_n = 1'b1;

        // 17 back-to-back instructions: 4-bit counter wraps to 1.
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 1'b1, 5'(14 + (i % 8)), 2'b00, 64'(i), 64'h0, 2'b00, 1'b0);
            tick();
            if (i == 0) begin
                chk("post_rst_rd",   64'(wb_rd),   64'd14);
                chk("post_rst_we",   64'(wb_we),   64'h1);
                chk("post_rst_data", wb_data,      64'h0);
            end
        end
        drive(1'b0, 1'b0, 5'd0, 2'b00, 64'h0, 64'h0, 2'b00, 1'b0);
        tick();
        chk("wrap_c4",  64'(c4_retired), 64'd1);
        chk("wrap_ref", 64'(retired),    64'd17);
        tick();
        tick();
        chk("wrap_idle_c4", 64'(c4_retired), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
